pushbutton_conditioner: RTL and testbench

- Input-conditioning stage directly upstream of the match-stick game FSM.
- Takes raw active-low pushbuttons and raw dip switches from the board pins.
- Synchronises and debounces every button and produces one-cycle press/release pulses.
- Captures the dip-switch "take" value and its range flag on a button-0 press, so the game consumes one clean move event per physical press.

---
 rtl/pushbutton_conditioner.sv | 137 +++++++++++++
 tb/tb_pushbutton_conditioner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pushbutton_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : pushbutton_conditioner
// Description : Input conditioning for the match-stick game. Active-low raw
//               pushbuttons are inverted, synchronised (2 flops) and
//               debounced per channel into a clean level plus one-cycle
//               press/release pulses. Raw dip switches are synchronised
//               (2 flops) and sampled on every accepted button-0 press to
//               produce one move event (take_value, take_legal, move_valid).
// Ports       : clk          - system clock, rising edge
//               rst          - asynchronous reset, active high
//               pushbuttons  - raw buttons, active low, asynchronous
//               dipswitches  - raw dip switches, asynchronous
//               btn_level    - debounced level, 1 = held
//               btn_press    - one-cycle pulse on accepted press
//               btn_release  - one-cycle pulse on accepted release
//               take_value   - switch value captured at last button-0 press
//               take_legal   - take_value within [MIN_TAKE, MAX_TAKE]
//               move_valid   - one-cycle pulse, new take_value/take_legal
// Revision    : 1.0 - initial release
// ============================================================================
module pushbutton_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int MIN_TAKE        = 1,
    parameter int MAX_TAKE        = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] pushbuttons,
    input  logic [3:0]       dipswitches,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [3:0]       take_value,
    output logic             take_legal,
    output logic             move_valid
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] r_btn_sync1;
    logic [N_BTN-1:0] r_btn_sync2;
    logic [3:0]       r_sw_sync1;
    logic [3:0]       r_sw_sync2;
    logic [N_BTN-1:0] w_press_next;
    logic             w_sw_legal;
    logic [3:0]       r_take_value;
    logic             r_take_legal;
    logic             r_move_valid;

    // Buttons are inverted before the first flop so the synchronised domain
    // is active-high and the reset value 0 means "released".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_sync1 <= '0;
            r_btn_sync2 <= '0;
            r_sw_sync1  <= '0;
            r_sw_sync2  <= '0;
        end else begin
            r_btn_sync1 <= ~pushbuttons;
            r_btn_sync2 <= r_btn_sync1;
            r_sw_sync1  <= dipswitches;
            r_sw_sync2  <= r_sw_sync1;
        end
    end

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_btn
            logic [CNT_W-1:0] r_cnt;
            logic             r_level;
            logic             r_press;
            logic             r_release;
            logic             w_differs;
            logic             w_accept;

            assign w_differs = (r_btn_sync2[i] != r_level);
            // Level flips once the new value has been seen for the full
            // debounce window; the counter restarts on any agreeing sample,
            // so it never exceeds DEBOUNCE_CYCLES-1.
            assign w_accept  = w_differs && (r_cnt == c_CNT_LAST);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt     <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else if (!w_differs) begin
                    r_cnt     <= '0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else if (w_accept) begin
                    r_cnt     <= '0;
                    r_level   <= ~r_level;
                    r_press   <= ~r_level;
                    r_release <= r_level;
                end else begin
                    r_cnt     <= r_cnt + CNT_W'(1);
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end
            end

            assign w_press_next[i] = w_accept && !r_level;
            assign btn_level[i]    = r_level;
            assign btn_press[i]    = r_press;
            assign btn_release[i]  = r_release;
        end
    endgenerate

    assign w_sw_legal = (int'(r_sw_sync2) >= MIN_TAKE) &&
                        (int'(r_sw_sync2) <= MAX_TAKE);

    // Only button 0 is a move; the capture happens on the same edge that
    // raises btn_press[0], so move_valid and btn_press[0] coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_take_value <= '0;
            r_take_legal <= 1'b0;
            r_move_valid <= 1'b0;
        end else if (w_press_next[0]) begin
            r_take_value <= r_sw_sync2;
            r_take_legal <= w_sw_legal;
            r_move_valid <= 1'b1;
        end else begin
            r_move_valid <= 1'b0;
        end
    end

    assign take_value = r_take_value;
    assign take_legal = r_take_legal;
    assign move_valid = r_move_valid;

endmodule
`default_nettype wire

// File: tb/tb_pushbutton_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_pushbutton_conditioner
// Description : Scoreboard bench for pushbutton_conditioner. Stimulus pushes
//               the expected pulse event (cycle, levels, pulses, take) into a
//               queue; a negedge monitor pops and compares whenever the DUT
//               shows a pulse, and flags overdue or unexpected events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pushbutton_conditioner;

    localparam int c_DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] pushbuttons;
    logic [3:0] dipswitches;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [3:0] take_value;
    logic       take_legal;
    logic       move_valid;

    pushbutton_conditioner #(
        .N_BTN           (2),
        .DEBOUNCE_CYCLES (c_DEB),
        .CNT_W           (4),
        .MIN_TAKE        (1),
        .MAX_TAKE        (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pushbuttons (pushbuttons),
        .dipswitches (dipswitches),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .take_value  (take_value),
        .take_legal  (take_legal),
        .move_valid  (move_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] lvl;
        logic [1:0] prs;
        logic [1:0] rel;
        logic       mv;
        logic [3:0] tv;
        logic       tl;
    } ev_t;

    ev_t        q[$];
    int         cyc = 0;
    int         compared = 0;
    int         mismatched = 0;
    logic [1:0] cur = 2'b00;
    logic [3:0] exp_tv = 4'd0;
    logic       exp_tl = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse cycle must match the head of the queue exactly.
    always @(negedge clk) begin
        ev_t e;
        if ((|btn_press) || (|btn_release) || move_valid) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_pulse cyc=%0d got press=%b rel=%b mv=%b required no pulse",
                         cyc, btn_press, btn_release, move_valid);
            end else begin
                e = q.pop_front();
                if (cyc != e.cyc || btn_level != e.lvl || btn_press != e.prs ||
                    btn_release != e.rel || move_valid != e.mv ||
                    take_value != e.tv || take_legal != e.tl) begin
                    mismatched++;
                    $display("FAIL pulse_event got cyc=%0d lvl=%b prs=%b rel=%b mv=%b tv=%0d tl=%b required cyc=%0d lvl=%b prs=%b rel=%b mv=%b tv=%0d tl=%b",
                             cyc, btn_level, btn_press, btn_release, move_valid, take_value, take_legal,
                             e.cyc, e.lvl, e.prs, e.rel, e.mv, e.tv, e.tl);
                end
            end
        end else if (q.size() > 0 && cyc > q[0].cyc) begin
            compared++;
            mismatched++;
            $display("FAIL missing_pulse at cyc=%0d got no pulse required event at cyc=%0d prs=%b rel=%b",
                     cyc, q[0].cyc, q[0].prs, q[0].rel);
            void'(q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        compared++;
        if (btn_level != 0 || btn_press != 0 || btn_release != 0 ||
            take_value != 0 || take_legal != 0 || move_valid != 0) begin
            mismatched++;
            $display("FAIL %s got lvl=%b prs=%b rel=%b tv=%0d tl=%b mv=%b required all zero",
                     name, btn_level, btn_press, btn_release, take_value, take_legal, move_valid);
        end
    endtask

    // Drive a new held-button state and queue the event expected at
    // edge k+1+DEBOUNCE_CYCLES, k being the first edge after the drive.
    task automatic drive(input logic [1:0] nw);
        ev_t        e;
        logic [1:0] p;
        logic [1:0] r;
        p = nw & ~cur;
        r = cur & ~nw;
        pushbuttons = ~nw;
        if (p[0]) begin
            exp_tv = dipswitches;
            exp_tl = (dipswitches >= 4'd1) && (dipswitches <= 4'd10);
        end
        if ((p | r) != 2'b00) begin
            e.cyc = cyc + 2 + c_DEB;
            e.lvl = nw;
            e.prs = p;
            e.rel = r;
            e.mv  = p[0];
            e.tv  = exp_tv;
            e.tl  = exp_tl;
            q.push_back(e);
        end
        cur = nw;
        tick(10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no end of test required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pushbuttons = 2'b11;
        dipswitches = 4'd0;
        tick(3);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_idle("reset_idle");
        end

        // Clean press/release with a legal take.
        dipswitches = 4'd3;
        tick(3);
        drive(2'b01);
        drive(2'b00);

        // Bounce: two 3-cycle low bursts must not be accepted.
        pushbuttons[0] = 1'b0; tick(3);
        pushbuttons[0] = 1'b1; tick(1);
        pushbuttons[0] = 1'b0; tick(3);
        pushbuttons[0] = 1'b1; tick(10);
        compared++;
        if (btn_level != 2'b00) begin
            mismatched++;
            $display("FAIL bounce_level got %b required 00", btn_level);
        end

        // Take boundaries.
        dipswitches = 4'd0;  drive(2'b01); drive(2'b00);
        dipswitches = 4'd11; drive(2'b01); drive(2'b00);
        dipswitches = 4'd10; drive(2'b01); drive(2'b00);
        dipswitches = 4'd1;  drive(2'b01); drive(2'b00);
        dipswitches = 4'd15; drive(2'b01); drive(2'b00);

        // Button 1 never captures, even if switches move while held.
        dipswitches = 4'd7;
        drive(2'b10);
        dipswitches = 4'd9;
        drive(2'b00);
        compared++;
        if (take_value != 4'd15 || take_legal != 1'b0) begin
            mismatched++;
            $display("FAIL btn1_take_hold got tv=%0d tl=%b required tv=15 tl=0",
                     take_value, take_legal);
        end

        // Both buttons on the same edge.
        dipswitches = 4'd4;
        drive(2'b11);
        drive(2'b00);

        // Asynchronous reset in the middle of a button-0 debounce.
        drive(2'b10);
        dipswitches = 4'd6;
        pushbuttons[0] = 1'b0;
        tick(2);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_reset_clear");
        pushbuttons = 2'b11;
        cur = 2'b00;
        exp_tv = 4'd0;
        exp_tl = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(20);
        check_idle("after_reset_idle");

        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL leftover_events got %0d pending required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
